// File: rtl/array_feeder_if.sv
// Accumulator-side bus of the array feeder: clear/start/data toward the
// accumulator, done/sum back from it.
interface array_feeder_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
);
    logic              acc_clear;
    logic              acc_start;
    logic [DATA_W-1:0] acc_data;
    logic              acc_done;
    logic [SUM_W-1:0]  acc_sum;

    modport master (
        output acc_clear, acc_start, acc_data,
        input  acc_done, acc_sum
    );

    modport slave (
        input  acc_clear, acc_start, acc_data,
        output acc_done, acc_sum
    );
endinterface

// File: rtl/array_feeder.sv
// Streams a small byte buffer into the byte-summing accumulator and checks
// the returned sum against a locally computed reference.
//
// state  | meaning
// IDLE   | buffer writable, waiting for go
// CLEAR  | one-cycle synchronous clear of the accumulator
// STREAM | DEPTH cycles presenting buffer bytes with start high
// WAIT   | start held high until acc_done or the timeout down-counter expires
// REPORT | one-cycle result_valid pulse
module array_feeder #(
    parameter int DEPTH   = 5,
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    output logic              busy,
    array_feeder_if.master    acc,
    output logic [SUM_W-1:0]  result,
    output logic              result_valid,
    output logic              mismatch,
    output logic              timeout_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, REPORT} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [SUM_W-1:0]    lsum, lsum_nxt;
    logic [TW-1:0]       wcnt, wcnt_nxt;
    logic                clear_nxt, start_nxt, rv_nxt, mism_nxt, tmo_nxt, busy_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic [SUM_W-1:0]    result_nxt;
    logic                wr_ok;

    assign wr_ok = (state == IDLE) && wr_en && ({1'b0, wr_addr} < 4'(DEPTH));

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        lsum_nxt   = lsum;
        wcnt_nxt   = wcnt;
        clear_nxt  = 1'b0;
        start_nxt  = 1'b0;
        data_nxt   = '0;
        rv_nxt     = 1'b0;
        result_nxt = result;
        mism_nxt   = mismatch;
        tmo_nxt    = timeout_err;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = CLEAR;
                    clear_nxt = 1'b1;
                    mism_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                end
            end
            CLEAR: begin
                state_nxt = STREAM;
                idx_nxt   = '0;
                lsum_nxt  = '0;
                start_nxt = 1'b1;
                data_nxt  = mem[0];
            end
            STREAM: begin
                lsum_nxt  = lsum + SUM_W'(mem[idx]);
                start_nxt = 1'b1;
                if (idx == IDX_W'(DEPTH - 1)) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = TW'(TIMEOUT - 1);
                end else begin
                    idx_nxt  = IDX_W'(idx + 1'b1);
                    data_nxt = mem[IDX_W'(idx + 1'b1)];
                end
            end
            WAIT: begin
                // done on the terminal-count cycle still counts as a result
                if (acc.acc_done) begin
                    state_nxt  = REPORT;
                    result_nxt = acc.acc_sum;
                    mism_nxt   = (acc.acc_sum != lsum);
                    rv_nxt     = 1'b1;
                end else if (wcnt == '0) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 1'b1;
                    mism_nxt  = 1'b0;
                end else begin
                    wcnt_nxt  = wcnt - 1'b1;
                    start_nxt = 1'b1;
                end
            end
            REPORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            lsum          <= '0;
            wcnt          <= '0;
            busy          <= 1'b0;
            acc.acc_clear <= 1'b0;
            acc.acc_start <= 1'b0;
            acc.acc_data  <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            mismatch      <= 1'b0;
            timeout_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            lsum          <= lsum_nxt;
            wcnt          <= wcnt_nxt;
            busy          <= busy_nxt;
            acc.acc_clear <= clear_nxt;
            acc.acc_start <= start_nxt;
            acc.acc_data  <= data_nxt;
            result        <= result_nxt;
            result_valid  <= rv_nxt;
            mismatch      <= mism_nxt;
            timeout_err   <= tmo_nxt;
            if (wr_ok) mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder with a behavioural accumulator and a
// scoreboard of expected stream bytes and results.
module tb_array_feeder;
    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       go = 1'b0;
    logic       busy, result_valid, mismatch, timeout_err;
    logic [15:0] result;

    array_feeder_if #(.DATA_W(8), .SUM_W(16)) acc ();

    array_feeder #(.DEPTH(DEPTH), .DATA_W(8), .SUM_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .go(go), .busy(busy), .acc(acc), .result(result),
        .result_valid(result_valid), .mismatch(mismatch), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // accumulator model: 0 normal, 1 sum off by one, 2 never done
    int          mode = 0;
    logic [15:0] m_sum = '0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        if (acc.acc_clear) begin
            m_sum  <= '0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (acc.acc_start) begin
            if (m_cnt < DEPTH) begin
                m_sum <= m_sum + 16'(acc.acc_data);
                m_cnt <= m_cnt + 1;
            end else begin
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    assign acc.acc_done = m_done && (mode != 2);
    assign acc.acc_sum  = (mode == 1) ? m_sum - 16'd1 : m_sum;

    int n_checks = 0;
    int n_errors = 0;
    int rv_count = 0;
    logic [7:0]  model_mem [DEPTH];
    logic [7:0]  exp_data_q[$];
    logic [16:0] exp_res_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // stream monitor: after each acc_clear, DEPTH bytes with start high
    initial begin
        int left = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                left = 0;
            end else if (acc.acc_clear) begin
                chk("clear_start_low", {31'd0, acc.acc_start}, 0);
                chk("clear_data_zero", {24'd0, acc.acc_data}, 0);
                left = DEPTH;
            end else if (left > 0) begin
                if (exp_data_q.size() == 0) begin
                    chk("stream_unexpected", 1, 0);
                end else begin
                    chk("stream_data", {24'd0, acc.acc_data}, {24'd0, exp_data_q.pop_front()});
                end
                chk("stream_start", {31'd0, acc.acc_start}, 1);
                left--;
            end
        end
    end

    // result monitor
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && result_valid) begin
                rv_count++;
                if (exp_res_q.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin
                    e = exp_res_q.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e[15:0]});
                    chk("mismatch", {31'd0, mismatch}, {31'd0, e[16]});
                    chk("rv_timeout_low", {31'd0, timeout_err}, 0);
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input bit stores);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (stores) model_mem[a] = d;
    endtask

    task automatic load(input logic [7:0] d0, d1, d2, d3, d4);
        wr(3'd0, d0, 1); wr(3'd1, d1, 1); wr(3'd2, d2, 1); wr(3'd3, d3, 1); wr(3'd4, d4, 1);
    endtask

    task automatic push_exp(input logic [15:0] r, input bit m, input bit with_res);
        for (int i = 0; i < DEPTH; i++) exp_data_q.push_back(model_mem[i]);
        if (with_res) exp_res_q.push_back({m, r});
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1);
    end

    initial begin
        int lat, starts, rv0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_clear", {31'd0, acc.acc_clear}, 0);
        chk("rst_start", {31'd0, acc.acc_start}, 0);
        chk("rst_result", {16'd0, result}, 0);
        chk("rst_flags", {29'd0, result_valid, mismatch, timeout_err}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic transfer with latency measurement
        load(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
        push_exp(16'd150, 0, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        lat = 1;
        while (!result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, DEPTH + 4);
        chk("report_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("busy_after_report", {31'd0, busy}, 0);
        chk("rv_once", rv_count, 1);
        chk("hold_result", {16'd0, result}, 150);

        // all 0xFF, back to back
        load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_exp(16'd1275, 0, 1);
        pulse_go();
        wait_idle();
        push_exp(16'd1275, 0, 1);
        pulse_go();
        wait_idle();
        chk("ff_repeat_result", {16'd0, result}, 1275);

        // accumulator returns a wrong sum
        load(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
        mode = 1;
        push_exp(16'd149, 1, 1);
        pulse_go();
        wait_idle();
        chk("mismatch_held", {31'd0, mismatch}, 1);
        mode = 0;

        // no done: timeout after 15 wait cycles
        mode = 2;
        rv0 = rv_count;
        push_exp(16'd0, 0, 0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        starts = 0;
        for (int n = 0; n < 100 && busy; n++) begin
            @(negedge clk);
            if (acc.acc_start) starts++;
        end
        chk("timeout_wait_cycles", starts - DEPTH, 15);
        chk("timeout_err", {31'd0, timeout_err}, 1);
        chk("timeout_busy", {31'd0, busy}, 0);
        chk("timeout_result_kept", {16'd0, result}, 149);
        chk("timeout_mismatch", {31'd0, mismatch}, 0);
        chk("timeout_no_rv", rv_count, rv0);
        mode = 0;

        // next go clears timeout_err; write and go during STREAM are ignored
        push_exp(16'd150, 0, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("go_clears_timeout", {31'd0, timeout_err}, 0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h99; go = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; go = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("go_not_queued", {31'd0, busy}, 0);

        // out-of-range write in IDLE
        wr(3'd6, 8'h77, 0);
        push_exp(16'd150, 0, 1);
        pulse_go();
        wait_idle();

        // asynchronous reset on the 3rd STREAM cycle
        push_exp(16'd0, 0, 0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_start", {31'd0, acc.acc_start}, 0);
        chk("arst_data", {24'd0, acc.acc_data}, 0);
        chk("arst_result", {16'd0, result}, 0);
        chk("arst_flags", {28'd0, acc.acc_clear, result_valid, mismatch, timeout_err}, 0);
        @(negedge clk);
        exp_data_q.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        push_exp(16'd15, 0, 1);
        pulse_go();
        wait_idle();
        repeat (2) @(negedge clk);
        chk("final_result", {16'd0, result}, 15);
        chk("res_queue_empty", exp_res_q.size(), 0);
        chk("data_queue_empty", exp_data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/array_feeder.md
Name: array_feeder

Overview:
- Source-side companion to the team's byte-summing accumulator.
- Holds a small buffer of DEPTH bytes loaded through a write port. On command it clears the accumulator, streams the bytes one per cycle, then holds start until the accumulator reports done.
- Captures the returned sum, checks it against a locally computed reference sum, and reports result, mismatch or timeout to the controlling logic.

Parameters:
- DEPTH, 5, number of bytes streamed per transfer; must equal the accumulator's element count.
- DATA_W, 8, byte width.
- SUM_W, 16, sum width.
- TIMEOUT, 15, maximum WAIT cycles before acc_done is declared missing.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  3  buffer index.
- wr_data  input  DATA_W  buffer write data.
- go  input  1  start-transfer request, sampled in IDLE.
- busy  output  1  high in every state except IDLE.
- acc_clear  output  1  synchronous clear to the accumulator (its reset).
- acc_start  output  1  drives the accumulator's start.
- acc_data  output  DATA_W  drives the accumulator's data_in.
- acc_done  input  1  accumulator done.
- acc_sum  input  SUM_W  accumulator sum.
- result  output  SUM_W  last captured acc_sum.
- result_valid  output  1  one-cycle pulse when result updates.
- mismatch  output  1  high if the last captured acc_sum differed from the local sum.
- timeout_err  output  1  high if the last transfer timed out.

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, FSM to IDLE, buffer contents all 0, counters 0.
- Buffer writes:
  - Accepted only in IDLE when wr_en=1 and wr_addr < DEPTH.
  - Writes with wr_addr >= DEPTH, or writes while busy, are ignored.
- FSM states: IDLE, CLEAR, STREAM, WAIT, REPORT.
- IDLE:
  - go=1 moves to CLEAR on the next edge, and clears mismatch and timeout_err on that edge.
  - If wr_en and go arrive in the same cycle, the write commits on that edge and the new value is streamed.
- CLEAR (exactly 1 cycle):
  - acc_clear=1, acc_start=0, acc_data=0.
  - Local sum and index reset to 0.
  - Moves to STREAM.
- STREAM (exactly DEPTH cycles):
  - acc_start=1 and acc_data=buf[idx], with idx counting 0..DEPTH-1.
  - Each cycle, local_sum += zero-extended buf[idx] (SUM_W wide; wraps modulo 2^SUM_W, no saturation).
  - After idx=DEPTH-1, moves to WAIT.
- WAIT:
  - acc_start held at 1 and acc_data=0; the accumulator requires start held high to assert done.
  - A wait counter increments every cycle.
  - acc_done=1: capture acc_sum into result, set mismatch=(acc_sum != local_sum), move to REPORT.
  - Counter reaches TIMEOUT with no acc_done: timeout_err=1, result unchanged, mismatch=0, return to IDLE with no result_valid.
  - If acc_done and the final timeout cycle coincide, acc_done wins.
- REPORT (1 cycle): result_valid=1, acc_start=0; returns to IDLE.
- Outputs hold between transfers:
  - result, mismatch and timeout_err hold until the next go or reset.
  - acc_start and acc_clear are 0 in IDLE.
- go while busy is ignored; it is not queued.
- Latency with the standard accumulator (done seen on the 2nd WAIT cycle): go sampled at edge E0 → result_valid high in the cycle after edge E0+DEPTH+3, i.e. 1+DEPTH+2+1 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The accumulator is not separately cleared; the next transfer's CLEAR handles it.
- All outputs are registered.

Test Plan:
- Load 10,20,30,40,50 at addresses 0..4, pulse go, bench instantiates the real accumulator:
  - acc_clear for 1 cycle, then acc_data 10,20,30,40,50 on consecutive cycles.
  - result=150, result_valid pulses once, mismatch=0, timeout_err=0, busy drops after REPORT.
- Load 0xFF at all 5 addresses, go → result=1275 (0x04FB), mismatch=0. Repeat go immediately after → the second result is again 1275, proving CLEAR works.
- Bench model drives acc_done with acc_sum=149 for the 10..50 buffer → result=149, mismatch=1, result_valid pulses.
- acc_done tied 0 → acc_start stays high for exactly 15 WAIT cycles, then timeout_err=1, result keeps its prior value, no result_valid pulse, busy=0. The next go clears timeout_err.
- Buffer write and go handling:
  - During STREAM, write wr_addr=2 with 0x99 and pulse go → buffer unchanged, transfer completes normally.
  - wr_addr=6 while IDLE → no buffer change.
- Assert reset_n=0 asynchronously on the 3rd STREAM cycle → outputs 0 immediately, FSM in IDLE. After release, go with the buffer reloaded to 1,2,3,4,5 → result=15.
